// File: rtl/multi_channel_time_editor_if.sv
// Bus between the time editor and its surroundings: button levels and channel
// values in, display/blink/load strobe out.
//
// Load handshake: PE is a valid-only strobe with no ready. It is high for
// exactly one cycle per commit, and load_ch/load_value are meaningful in that
// cycle. The owning counter must accept the load in that cycle. Outside PE,
// load_ch/load_value keep the last committed pair.
interface multi_channel_time_editor_if #(
  parameter int NUM_CH     = 2,
  parameter int NUM_FIELDS = 4
);
  localparam int TW = 8 * NUM_FIELDS;
  localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic [CW-1:0]           ch_sel;
  logic [NUM_CH*TW-1:0]    ch_time;
  logic                    adjust;
  logic                    left;
  logic                    right;
  logic                    up;
  logic                    down;
  logic                    apply;
  logic [TW-1:0]           display_time;
  logic [2*NUM_FIELDS-1:0] blink_mask;
  logic                    editing;
  logic                    PE;
  logic [CW-1:0]           load_ch;
  logic [TW-1:0]           load_value;
  logic [1:0]              state_dbg;

  modport master (
    output ch_sel, ch_time, adjust, left, right, up, down, apply,
    input  display_time, blink_mask, editing, PE, load_ch, load_value, state_dbg
  );

  modport slave (
    input  ch_sel, ch_time, adjust, left, right, up, down, apply,
    output display_time, blink_mask, editing, PE, load_ch, load_value, state_dbg
  );
endinterface

// File: rtl/multi_channel_time_editor.sv
// Multi-channel BCD time editor: shows the selected channel, runs a cursor
// edit session on a snapshot, and commits it with a one-cycle load strobe.
module multi_channel_time_editor #(
  parameter int                      NUM_CH     = 2,
  parameter int                      NUM_FIELDS = 4,
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX  = {8'd23, 8'd59, 8'd59, 8'd99},
  parameter int                      REPEAT_DLY = 500,
  parameter int                      REPEAT_PER = 100,
  parameter int                      BLINK_HALF = 250
) (
  input logic                        CP,
  input logic                        CR,
  multi_channel_time_editor_if.slave bus
);
  localparam int TW = 8 * NUM_FIELDS;
  localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int FW = (NUM_FIELDS > 2) ? $clog2(NUM_FIELDS) : 1;
  localparam int RW = $clog2(REPEAT_DLY + REPEAT_PER + 1);
  localparam int BW = $clog2(2 * BLINK_HALF + 1);

  localparam logic [RW-1:0] REP_FIRE = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DLY + REPEAT_PER - 1);
  localparam logic [BW-1:0] BLK_HALF = BW'(BLINK_HALF);
  localparam logic [BW-1:0] BLK_LAST = BW'(2 * BLINK_HALF - 1);
  localparam logic [FW-1:0] CUR_LAST = FW'(NUM_FIELDS - 1);
  localparam logic [CW:0]   CH_COUNT = (CW + 1)'(NUM_CH);

  // Button bit positions in the registered button vector
  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;
  localparam int B_ADJ   = 4;
  localparam int B_APPLY = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [5:0]              r_btn;
  logic [5:0]              r_btn_q;
  logic [5:0]              w_btn;
  logic [5:0]              w_ev;
  logic [RW-1:0]           r_rep;
  logic [BW-1:0]           r_blink;
  logic [FW-1:0]           r_cur;
  logic [TW-1:0]           r_buf;
  logic [CW-1:0]           r_edit_ch;
  logic [CW-1:0]           r_load_ch;
  logic [TW-1:0]           r_load_val;
  logic [CW-1:0]           w_sel;
  logic [TW-1:0]           w_ch [NUM_CH];
  logic [TW-1:0]           w_buf_up;
  logic [TW-1:0]           w_buf_dn;
  logic                    w_hold;
  logic                    w_rep;
  logic                    w_step_up;
  logic                    w_step_dn;
  logic                    w_move_r;
  logic                    w_move_l;
  logic                    w_pe;
  logic                    w_editing;
  logic                    w_show_buf;
  logic [2*NUM_FIELDS-1:0] w_mask;

  assign w_btn = {bus.apply, bus.adjust, bus.down, bus.up, bus.right, bus.left};
  assign w_ev  = r_btn & ~r_btn_q;

  // Unpack the channel bus; out-of-range selects fall back to channel 0
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_ch[c] = bus.ch_time[c*TW +: TW];
  end
  assign w_sel = ({1'b0, bus.ch_sel} < CH_COUNT) ? bus.ch_sel : '0;

  // Auto-repeat fires only while exactly one of up/down is held
  assign w_hold    = r_btn[B_UP] ^ r_btn[B_DOWN];
  assign w_rep     = w_hold && (r_rep == REP_FIRE);
  assign w_step_up = r_btn[B_UP] & ~r_btn[B_DOWN] & (w_ev[B_UP] | w_rep);
  assign w_step_dn = r_btn[B_DOWN] & ~r_btn[B_UP] & (w_ev[B_DOWN] | w_rep);
  assign w_move_r  = w_ev[B_RIGHT] & ~w_ev[B_LEFT];
  assign w_move_l  = w_ev[B_LEFT] & ~w_ev[B_RIGHT];

  // Per-field BCD up/down values; invalid snapshots collapse to 00
  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    localparam logic [7:0] MAXB    = FIELD_MAX[8*f +: 8];
    localparam logic [7:0] MAX_BCD = {4'(MAXB / 8'd10), 4'(MAXB % 8'd10)};
    logic [3:0] w_t;
    logic [3:0] w_u;
    logic [7:0] w_bin;
    logic       w_ok;
    logic [7:0] w_inc;
    logic [7:0] w_dec;

    assign w_t   = r_buf[8*f+4 +: 4];
    assign w_u   = r_buf[8*f +: 4];
    assign w_bin = 8'(w_t) * 8'd10 + 8'(w_u);
    assign w_ok  = (w_t <= 4'd9) && (w_u <= 4'd9) && (w_bin <= MAXB);
    assign w_inc = (!w_ok || w_bin == MAXB) ? 8'h00 :
                   (w_u == 4'd9) ? {w_t + 4'd1, 4'd0} : {w_t, w_u + 4'd1};
    assign w_dec = !w_ok ? 8'h00 :
                   (w_bin == 8'd0) ? MAX_BCD :
                   (w_u == 4'd0) ? {w_t - 4'd1, 4'd9} : {w_t, w_u - 4'd1};

    assign w_buf_up[8*f +: 8] = (r_cur == FW'(f)) ? w_inc : r_buf[8*f +: 8];
    assign w_buf_dn[8*f +: 8] = (r_cur == FW'(f)) ? w_dec : r_buf[8*f +: 8];
  end

  // Button history: one register stage plus a previous-value stage for edges
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_btn   <= '0;
      r_btn_q <= '0;
    end else begin
      r_btn   <= w_btn;
      r_btn_q <= r_btn;
    end
  end

  // Hold-to-repeat counter: counts from the press, loops over the repeat period
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_rep <= '0;
    end else if (!w_hold) begin
      r_rep <= '0;
    end else if (r_rep == REP_LAST) begin
      r_rep <= REP_FIRE;
    end else begin
      r_rep <= r_rep + RW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and outputs; apply outranks cancel in EDIT
  always_comb begin
    w_next     = r_state;
    w_pe       = 1'b0;
    w_editing  = 1'b0;
    w_show_buf = 1'b0;
    w_mask     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_ev[B_ADJ]) w_next = S_EDIT;
      end
      S_EDIT: begin
        w_editing  = 1'b1;
        w_show_buf = 1'b1;
        if (r_blink >= BLK_HALF) begin
          for (int f = 0; f < NUM_FIELDS; f++) begin
            if (r_cur == FW'(f)) w_mask[2*f +: 2] = 2'b11;
          end
        end
        if (w_ev[B_APPLY])     w_next = S_COMMIT;
        else if (!r_btn[B_ADJ]) w_next = S_IDLE;
      end
      S_COMMIT: begin
        w_editing  = 1'b1;
        w_show_buf = 1'b1;
        w_pe       = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Edit datapath: snapshot, cursor, blink phase, field steps, commit capture
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_buf      <= '0;
      r_cur      <= '0;
      r_blink    <= '0;
      r_edit_ch  <= '0;
      r_load_ch  <= '0;
      r_load_val <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ev[B_ADJ]) begin
            r_edit_ch <= w_sel;
            r_buf     <= w_ch[w_sel];
            r_cur     <= '0;
            r_blink   <= '0;
          end
        end
        S_EDIT: begin
          if (w_ev[B_APPLY]) begin
            r_load_ch  <= r_edit_ch;
            r_load_val <= r_buf;
          end else if (r_btn[B_ADJ]) begin
            if (w_move_r || w_move_l) begin
              if (w_move_r) r_cur <= (r_cur == CUR_LAST) ? '0 : r_cur + FW'(1);
              else          r_cur <= (r_cur == '0) ? CUR_LAST : r_cur - FW'(1);
              r_blink <= '0;
            end else begin
              r_blink <= (r_blink == BLK_LAST) ? '0 : r_blink + BW'(1);
              if (w_step_up)      r_buf <= w_buf_up;
              else if (w_step_dn) r_buf <= w_buf_dn;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.display_time = w_show_buf ? r_buf : w_ch[w_sel];
  assign bus.blink_mask   = w_mask;
  assign bus.editing      = w_editing;
  assign bus.PE           = w_pe;
  assign bus.load_ch      = r_load_ch;
  assign bus.load_value   = r_load_val;
  assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_multi_channel_time_editor.sv
// Testbench for multi_channel_time_editor: directed steps plus randomized
// edit sessions checked against a decimal-arithmetic model of the editor.
module tb_multi_channel_time_editor;
  localparam int NUM_CH     = 2;
  localparam int NUM_FIELDS = 4;
  localparam int TW         = 8 * NUM_FIELDS;
  localparam int CW         = 1;
  localparam int DLY        = 500;
  localparam int PER        = 100;
  localparam int HALF       = 250;

  // Clock / reset
  logic CP = 1'b0;
  logic CR = 1'b1;
  always #5 CP = ~CP;

  multi_channel_time_editor_if #(.NUM_CH(NUM_CH), .NUM_FIELDS(NUM_FIELDS)) bus ();

  multi_channel_time_editor #(.NUM_CH(NUM_CH), .NUM_FIELDS(NUM_FIELDS)) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  // Scoreboard and reference model state
  int            n_vec = 0;
  int            n_err = 0;
  int            fmax [NUM_FIELDS] = '{99, 59, 59, 23};
  logic [TW-1:0] ch [NUM_CH];
  logic [TW-1:0] m_buf;
  logic [TW-1:0] m_load_val;
  int            m_load_ch;
  int            m_cur;
  int            m_ch;
  logic [TW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CP);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // Decimal value of a BCD byte, or -1 if it is not a legal value for the field
  function automatic int field_val(input logic [7:0] b, input int mx);
    int t;
    int u;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9 || u > 9 || t * 10 + u > mx) return -1;
    return t * 10 + u;
  endfunction

  function automatic logic [TW-1:0] step(input logic [TW-1:0] v, input int f, input int dir);
    logic [TW-1:0] r;
    int x;
    int nv;
    r = v;
    x = field_val(v[8*f +: 8], fmax[f]);
    if (x < 0)        nv = 0;
    else if (dir > 0) nv = (x == fmax[f]) ? 0 : x + 1;
    else              nv = (x == 0) ? fmax[f] : x - 1;
    r[8*f +: 8] = to_bcd(nv);
    return r;
  endfunction

  // Steps taken by a hold whose last held cycle is last_k cycles after the press
  function automatic int rep_steps(input int last_k);
    return 1 + ((last_k >= DLY) ? 1 + (last_k - DLY) / PER : 0);
  endfunction

  function automatic logic [7:0] blink_exp(input int cur, input int j);
    logic [7:0] m;
    m = 8'h03 << (2 * cur);
    return (((j / HALF) % 2) == 1) ? m : 8'h00;
  endfunction

  // Driver tasks
  task automatic set_time();
    for (int c = 0; c < NUM_CH; c++) bus.ch_time[c*TW +: TW] = ch[c];
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       bus.left   = v;
      1:       bus.right  = v;
      2:       bus.up     = v;
      3:       bus.down   = v;
      4:       bus.apply  = v;
      default: bus.adjust = v;
    endcase
  endtask

  task automatic model_press(input int b);
    case (b)
      0:       m_cur = (m_cur == 0) ? NUM_FIELDS - 1 : m_cur - 1;
      1:       m_cur = (m_cur == NUM_FIELDS - 1) ? 0 : m_cur + 1;
      2:       m_buf = step(m_buf, m_cur, 1);
      default: m_buf = step(m_buf, m_cur, -1);
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(1);
    set_btn(b, 1'b0);
    tick(1);
    model_press(b);
  endtask

  task automatic start_edit();
    bus.adjust = 1'b0;
    tick(1);
    bus.adjust = 1'b1;
    tick(2);
    m_ch  = (int'(bus.ch_sel) < NUM_CH) ? int'(bus.ch_sel) : 0;
    m_buf = ch[m_ch];
    m_cur = 0;
  endtask

  task automatic commit_check(input string tag);
    bus.apply = 1'b1;
    tick(1);
    bus.apply = 1'b0;
    tick(1);
    m_load_val = m_buf;
    m_load_ch  = m_ch;
    chk({tag, "_pe"}, bus.PE, 64'd1);
    chk({tag, "_load_ch"}, bus.load_ch, 64'(m_load_ch));
    chk({tag, "_load_value"}, bus.load_value, m_load_val);
    tick(1);
    chk({tag, "_pe_drop"}, bus.PE, 64'd0);
    chk({tag, "_editing_drop"}, bus.editing, 64'd0);
  endtask

  initial begin
    logic [TW-1:0] base;
    int            j;
    int            pts [$];

    bus.ch_sel = CW'(1);
    bus.adjust = 1'b0;
    bus.left   = 1'b0;
    bus.right  = 1'b0;
    bus.up     = 1'b0;
    bus.down   = 1'b0;
    bus.apply  = 1'b0;
    ch[0] = 32'h12345678;
    ch[1] = 32'h23595999;
    set_time();
    m_load_val = '0;
    m_load_ch  = 0;

    // Reset state
    CR = 1'b1;
    tick(2);
    CR = 1'b0;
    tick(1);
    chk("rst_display", bus.display_time, 32'h23595999);
    chk("rst_editing", bus.editing, 64'd0);
    chk("rst_pe", bus.PE, 64'd0);
    chk("rst_blink", bus.blink_mask, 64'd0);
    chk("rst_load_ch", bus.load_ch, 64'd0);
    chk("rst_load_value", bus.load_value, 64'd0);

    // Basic edit and commit on channel 0
    bus.ch_sel = CW'(0);
    start_edit();
    chk("enter_editing", bus.editing, 64'd1);
    chk("enter_display", bus.display_time, 32'h12345678);
    press(1);
    press(1);
    press(2);
    chk("up_f2_model", bus.display_time, m_buf);
    chk("up_f2_const", bus.display_time, 32'h12355678);
    bus.ch_sel = CW'(1);
    tick(1);
    chk("sel_ignored", bus.display_time, m_buf);
    commit_check("commit1");
    chk("commit1_hold_value", bus.load_value, 32'h12355678);
    chk("idle_display", bus.display_time, ch[1]);

    // adjust held high after commit must not reopen the session
    tick(5);
    chk("no_reenter", bus.editing, 64'd0);

    // Field limits and BCD carry
    ch[0] = 32'h23000009;
    set_time();
    bus.ch_sel = CW'(0);
    start_edit();
    press(0);
    chk("left_wrap_mask_on", bus.blink_mask, 64'd0);
    press(2);
    chk("f3_up_wrap", bus.display_time, m_buf);
    chk("f3_up_wrap_const", bus.display_time, 32'h00000009);
    press(3);
    chk("f3_down_wrap", bus.display_time, 32'h23000009);
    press(1);
    press(2);
    chk("f0_bcd_carry", bus.display_time, 32'h23000010);
    chk("f0_bcd_carry_model", bus.display_time, m_buf);

    // Simultaneous up+down and left+right are ignored
    bus.up = 1'b1; bus.down = 1'b1; tick(1);
    bus.up = 1'b0; bus.down = 1'b0; tick(1);
    chk("updown_ignored", bus.display_time, m_buf);
    bus.left = 1'b1; bus.right = 1'b1; tick(1);
    bus.left = 1'b0; bus.right = 1'b0; tick(1);
    press(2);
    chk("leftright_ignored", bus.display_time, m_buf);

    // Hold-to-repeat on field 1 starting at 00
    press(1);
    base = m_buf;
    bus.up = 1'b1;
    tick(502);
    m_buf = base;
    for (int k = 0; k < rep_steps(500); k++) m_buf = step(m_buf, m_cur, 1);
    chk("repeat_first", bus.display_time, m_buf);
    tick(299);
    bus.up = 1'b0;
    tick(3);
    m_buf = base;
    for (int k = 0; k < rep_steps(800); k++) m_buf = step(m_buf, m_cur, 1);
    chk("repeat_total", bus.display_time, m_buf);
    chk("repeat_total_f1", 64'(bus.display_time[15:8]), 64'h05);
    tick(300);
    chk("repeat_released", bus.display_time, m_buf);

    // Blink phase on field 3 after wrapping left
    press(0);
    press(0);
    pts = '{0, 249, 250, 499, 500, 749, 750};
    for (int k = 0; k < 4; k++) pts.push_back(750 + 300 * k + int'($urandom_range(1, 299)));
    j = 0;
    foreach (pts[k]) begin
      tick(pts[k] - j);
      j = pts[k];
      chk($sformatf("blink_j%0d", j), bus.blink_mask, blink_exp(m_cur, j));
    end

    // Cancel: buffer discarded, no strobe
    press(2);
    bus.adjust = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk($sformatf("cancel_pe_%0d", k), bus.PE, 64'd0);
    end
    chk("cancel_editing", bus.editing, 64'd0);
    chk("cancel_display", bus.display_time, ch[0]);
    chk("cancel_load_value", bus.load_value, m_load_val);

    // Reset during COMMIT kills the strobe immediately
    start_edit();
    bus.apply = 1'b1;
    tick(1);
    bus.apply = 1'b0;
    tick(1);
    chk("pre_reset_pe", bus.PE, 64'd1);
    CR = 1'b1;
    #1;
    chk("reset_commit_pe", bus.PE, 64'd0);
    chk("reset_commit_editing", bus.editing, 64'd0);
    tick(1);
    CR = 1'b0;
    bus.adjust = 1'b0;
    tick(2);
    chk("post_reset_pe", bus.PE, 64'd0);
    chk("post_reset_load", bus.load_value, 64'd0);

    // apply and adjust-fall together: commit wins
    bus.ch_sel = CW'(1);
    start_edit();
    press(3);
    bus.apply  = 1'b1;
    bus.adjust = 1'b0;
    tick(1);
    bus.apply = 1'b0;
    tick(1);
    chk("race_pe", bus.PE, 64'd1);
    chk("race_load_ch", bus.load_ch, 64'd1);
    chk("race_load_value", bus.load_value, m_buf);
    tick(1);
    chk("race_editing", bus.editing, 64'd0);

    // Randomized sessions with legal and illegal snapshot fields
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
          if ($urandom_range(0, 5) == 0) ch[c][8*f +: 8] = 8'($urandom_range(0, 255));
          else                           ch[c][8*f +: 8] = to_bcd(int'($urandom_range(0, fmax[f])));
        end
      end
      set_time();
      bus.ch_sel = CW'($urandom_range(0, NUM_CH - 1));
      tick(1);
      exp_q.push_back(ch[int'(bus.ch_sel)]);
      chk($sformatf("rand%0d_idle", s), bus.display_time, exp_q.pop_front());
      start_edit();
      for (int p = 0; p < 25; p++) begin
        press(int'($urandom_range(0, 3)));
        exp_q.push_back(m_buf);
        chk($sformatf("rand%0d_step%0d", s, p), bus.display_time, exp_q.pop_front());
      end
      commit_check($sformatf("rand%0d_commit", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
